// File: rtl/membus_ctl.sv
// Memory-cycle controller: turns a VMEM memory request into one external bus
// transaction with ack/timeout handling, then pulses memack back to the requester.
module membus_ctl #(
  parameter int AW      = 22,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memrq,
  input  logic          wrcyc,
  input  logic [AW-1:0] pma,
  input  logic [31:0]   md,
  output logic          memack,
  output logic [31:0]   mdin,
  output logic          mdin_load,
  output logic          nxm,
  output logic          busy,
  output logic          bus_req,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] LP_TC = 8'(TIMEOUT - 1);

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_memack;
  logic [31:0]   r_mdin;
  logic          r_mdin_load;
  logic          r_nxm;
  logic          r_busy;
  logic          r_bus_req;
  logic          r_bus_write;
  logic [AW-1:0] r_bus_addr;
  logic [31:0]   r_bus_wdata;

  state_t        w_state_nx;
  logic [7:0]    w_cnt_nx;
  logic          w_memack_nx;
  logic [31:0]   w_mdin_nx;
  logic          w_mdin_load_nx;
  logic          w_nxm_nx;
  logic          w_bus_req_nx;
  logic          w_bus_write_nx;
  logic [AW-1:0] w_bus_addr_nx;
  logic [31:0]   w_bus_wdata_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_memack    <= 1'b0;
      r_mdin      <= '0;
      r_mdin_load <= 1'b0;
      r_nxm       <= 1'b0;
      r_busy      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_memack    <= w_memack_nx;
      r_mdin      <= w_mdin_nx;
      r_mdin_load <= w_mdin_load_nx;
      r_nxm       <= w_nxm_nx;
      r_busy      <= (w_state_nx != ST_IDLE);
      r_bus_req   <= w_bus_req_nx;
      r_bus_write <= w_bus_write_nx;
      r_bus_addr  <= w_bus_addr_nx;
      r_bus_wdata <= w_bus_wdata_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_memack_nx    = 1'b0;
    w_mdin_nx      = r_mdin;
    w_mdin_load_nx = 1'b0;
    w_nxm_nx       = 1'b0;
    w_bus_req_nx   = r_bus_req;
    w_bus_write_nx = r_bus_write;
    w_bus_addr_nx  = r_bus_addr;
    w_bus_wdata_nx = r_bus_wdata;

    case (r_state)
      ST_IDLE: begin
        w_bus_req_nx = 1'b0;
        if (memrq) begin
          w_bus_write_nx = wrcyc;
          w_bus_addr_nx  = pma;
          w_bus_wdata_nx = md;
          w_bus_req_nx   = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = ST_REQ;
        end
      end
      ST_REQ: begin
        // A real ack beats a timeout landing on the same edge.
        if (bus_ack) begin
          w_state_nx   = ST_ACK;
          w_bus_req_nx = 1'b0;
          w_memack_nx  = 1'b1;
          if (!r_bus_write) begin
            w_mdin_nx      = bus_rdata;
            w_mdin_load_nx = 1'b1;
          end
        end else if (r_cnt == LP_TC) begin
          w_state_nx   = ST_ACK;
          w_bus_req_nx = 1'b0;
          w_memack_nx  = 1'b1;
          w_nxm_nx     = 1'b1;
          if (!r_bus_write) begin
            w_mdin_nx      = 32'hFFFF_FFFF;
            w_mdin_load_nx = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      ST_ACK:     w_state_nx = ST_RECOVER;
      ST_RECOVER: w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  assign memack    = r_memack;
  assign mdin      = r_mdin;
  assign mdin_load = r_mdin_load;
  assign nxm       = r_nxm;
  assign busy      = r_busy;
  assign bus_req   = r_bus_req;
  assign bus_write = r_bus_write;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_membus_ctl.sv
// Directed plus randomized bench for membus_ctl (TIMEOUT=4); expected results
// come from a per-transaction model: ack delay vs timeout decides outcome and timing.
module tb_membus_ctl;
  localparam int AW = 22;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          memrq, wrcyc;
  logic [AW-1:0] pma;
  logic [31:0]   md;
  logic          memack, mdin_load, nxm, busy;
  logic [31:0]   mdin;
  logic          bus_req, bus_write;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  int            checks   = 0;
  int            failures = 0;
  logic [31:0]   exp_mdin;

  membus_ctl #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memrq(memrq), .wrcyc(wrcyc), .pma(pma), .md(md),
    .memack(memack), .mdin(mdin), .mdin_load(mdin_load), .nxm(nxm), .busy(busy),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge in IDLE. dly = number of REQ cycles with bus_ack low
  // before the ack; dly >= TO means the ack never comes in time.
  task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                     input int dly, input logic [31:0] rd);
    bit is_to;
    int nreq;
    is_to = (dly >= TO);
    nreq  = is_to ? TO : dly + 1;
    chk("idle_busy", 64'(busy), 64'(0));
    memrq = 1'b1; wrcyc = wr; pma = a; md = d; bus_ack = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= nreq; k++) begin
      chk("req_high",   64'(bus_req),   64'(1));
      chk("req_addr",   64'(bus_addr),  64'(a));
      chk("req_write",  64'(bus_write), 64'(wr));
      chk("req_wdata",  64'(bus_wdata), 64'(d));
      chk("req_memack", 64'(memack),    64'(0));
      chk("req_busy",   64'(busy),      64'(1));
      memrq     = 1'($urandom_range(0, 1));
      wrcyc     = 1'($urandom_range(0, 1));
      pma       = AW'($urandom);
      md        = $urandom;
      bus_ack   = (!is_to && k == nreq);
      bus_rdata = bus_ack ? rd : $urandom;
      @(negedge clk);
    end
    if (!wr) exp_mdin = is_to ? 32'hFFFF_FFFF : rd;
    chk("ack_memack", 64'(memack),    64'(1));
    chk("ack_nxm",    64'(nxm),       64'(is_to));
    chk("ack_load",   64'(mdin_load), 64'(!wr));
    chk("ack_mdin",   64'(mdin),      64'(exp_mdin));
    chk("ack_busreq", 64'(bus_req),   64'(0));
    chk("ack_busy",   64'(busy),      64'(1));
    bus_ack = 1'b1; bus_rdata = $urandom; memrq = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rec_memack", 64'(memack),    64'(0));
    chk("rec_load",   64'(mdin_load), 64'(0));
    chk("rec_nxm",    64'(nxm),       64'(0));
    chk("rec_busy",   64'(busy),      64'(1));
    chk("rec_mdin",   64'(mdin),      64'(exp_mdin));
    bus_ack = 1'($urandom_range(0, 1)); memrq = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("end_busy",   64'(busy),    64'(0));
    chk("end_busreq", 64'(bus_req), 64'(0));
    chk("end_memack", 64'(memack),  64'(0));
    chk("end_mdin",   64'(mdin),    64'(exp_mdin));
    bus_ack = 1'b0; memrq = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] last_pma, exp_addr;
    logic [31:0]   last_rd;
    logic          prev_req;
    int            n_ack, last_ack;

    reset = 1'b1; memrq = 1'b0; wrcyc = 1'b0; pma = '0; md = '0;
    bus_ack = 1'b0; bus_rdata = '0; exp_mdin = '0;
    #3;
    chk("rst_busreq", 64'(bus_req),  64'(0));
    chk("rst_busy",   64'(busy),     64'(0));
    chk("rst_memack", 64'(memack),   64'(0));
    chk("rst_mdin",   64'(mdin),     64'(0));
    chk("rst_addr",   64'(bus_addr), 64'(0));
    chk("rst_wdata",  64'(bus_wdata),64'(0));
    @(negedge clk);
    reset = 1'b0;

    txn(1'b0, 22'h012345, 32'h1234_5678, 2, 32'hDEAD_BEEF);
    txn(1'b1, 22'h00ABCD, 32'h00C0_FFEE, 1, 32'h5555_5555);
    txn(1'b0, 22'h3FFFFF, 32'h0,         TO, 32'h7777_7777);
    txn(1'b0, 22'h000001, 32'h0,         TO - 1, 32'h0000_0001);
    txn(1'b1, 22'h155555, 32'hA5A5_A5A5, TO + 3, 32'h0);

    // Async reset in the middle of a bus cycle.
    memrq = 1'b1; wrcyc = 1'b0; pma = 22'h2AAAAA; md = 32'h0;
    @(negedge clk);
    chk("ar_busreq_pre", 64'(bus_req), 64'(1));
    memrq = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_busreq", 64'(bus_req),  64'(0));
    chk("ar_busy",   64'(busy),     64'(0));
    chk("ar_addr",   64'(bus_addr), 64'(0));
    chk("ar_mdin",   64'(mdin),     64'(0));
    exp_mdin = '0;
    #1 reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ar_no_memack", 64'(memack), 64'(0));
      chk("ar_no_busy",   64'(busy),   64'(0));
      chk("ar_no_mdin",   64'(mdin),   64'(0));
    end
    bus_ack = 1'b0;
    txn(1'b0, 22'h0F0F0F, 32'h0, 0, 32'hCAFE_F00D);

    // Back-to-back reads with memrq and bus_ack held high.
    n_ack = 0; last_ack = -1; prev_req = 1'b0; exp_addr = '0;
    memrq = 1'b1; wrcyc = 1'b0; bus_ack = 1'b1;
    pma = AW'($urandom); last_pma = pma;
    bus_rdata = $urandom; last_rd = bus_rdata;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus_req && !prev_req) exp_addr = last_pma;
      if (bus_req) chk("b2b_addr", 64'(bus_addr), 64'(exp_addr));
      if (memack) begin
        exp_mdin = last_rd;
        chk("b2b_mdin", 64'(mdin), 64'(exp_mdin));
        if (last_ack >= 0) chk("b2b_spacing", 64'(c - last_ack), 64'(4));
        last_ack = c;
        n_ack++;
      end
      prev_req  = bus_req;
      pma       = AW'($urandom); last_pma = pma;
      bus_rdata = $urandom;      last_rd  = bus_rdata;
    end
    chk("b2b_count", 64'(n_ack), 64'(4));
    memrq = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'(0));

    for (int i = 0; i < 24; i++)
      txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
          int'($urandom_range(0, TO + 1)), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
